// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared widths, encodings and slot-action decode for the EX->MEM register
package ex_mem_reg_pkg;

  localparam int REG_BUS_W        = 32;
  localparam int REG_ADD_BUS_W    = 5;
  localparam int DOUBLE_REG_BUS_W = 2 * REG_BUS_W;

  localparam logic [REG_BUS_W-1:0]     ZERO_WORD    = '0;
  localparam logic [REG_ADD_BUS_W-1:0] NOP_REG_ADDR = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } slot_act_e;

  // MEM stalled without EX is not a legal vector; it falls through to advance.
  function automatic slot_act_e slot_action(input logic flush,
                                            input logic ex_stall,
                                            input logic mem_stall);
    if (flush) begin
      return ACT_FLUSH;
    end
    if (ex_stall == STOP && mem_stall == NO_STOP) begin
      return ACT_BUBBLE;
    end
    if (ex_stall == STOP) begin
      return ACT_HOLD;
    end
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX->MEM pipeline register with stall hold/bubble and accumulate state carry
// Optional flush port and behaviour enabled by defining EX_MEM_FLUSH_EN.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_tmp_i,
  input  logic [1:0]          cnt_i,
`ifdef EX_MEM_FLUSH_EN
  input  logic                flush,
`endif
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_tmp_o,
  output logic [1:0]          cnt_o
);

  logic                flush_req;
  logic                unused_stall;
  slot_act_e           act;

  logic [ADDR_W-1:0]   mem_wd_d,    mem_wd_q;
  logic                mem_wreg_d,  mem_wreg_q;
  logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
  logic                mem_whilo_d, mem_whilo_q;
  logic [DATA_W-1:0]   mem_hi_d,    mem_hi_q;
  logic [DATA_W-1:0]   mem_lo_d,    mem_lo_q;
  logic                mem_valid_d, mem_valid_q;
  logic [2*DATA_W-1:0] hilo_tmp_d,  hilo_tmp_q;
  logic [1:0]          cnt_d,       cnt_q;

`ifdef EX_MEM_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign unused_stall = ^stall;
  assign act          = slot_action(flush_req, stall[EX_IDX], stall[MEM_IDX]);

  always_comb begin
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    mem_whilo_d = mem_whilo_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_valid_d = mem_valid_q;
    hilo_tmp_d  = hilo_tmp_q;
    cnt_d       = cnt_q;
    case (act)
      ACT_FLUSH: begin
        mem_wd_d    = '0;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = '0;
        mem_whilo_d = WRITE_DISABLE;
        mem_hi_d    = '0;
        mem_lo_d    = '0;
        mem_valid_d = 1'b0;
        hilo_tmp_d  = '0;
        cnt_d       = '0;
      end
      // The bubble clears the slot but keeps the accumulate partial product alive.
      ACT_BUBBLE: begin
        mem_wd_d    = '0;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = '0;
        mem_whilo_d = WRITE_DISABLE;
        mem_hi_d    = '0;
        mem_lo_d    = '0;
        mem_valid_d = 1'b0;
        hilo_tmp_d  = hilo_tmp_i;
        cnt_d       = cnt_i;
      end
      ACT_ADVANCE: begin
        mem_wd_d    = ex_wd;
        mem_wreg_d  = ex_wreg;
        mem_wdata_d = ex_wdata;
        mem_whilo_d = ex_whilo;
        mem_hi_d    = ex_hi;
        mem_lo_d    = ex_lo;
        mem_valid_d = 1'b1;
        hilo_tmp_d  = '0;
        cnt_d       = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mem_wd_q    <= '0;
      mem_wreg_q  <= WRITE_DISABLE;
      mem_wdata_q <= '0;
      mem_whilo_q <= WRITE_DISABLE;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_valid_q <= 1'b0;
      hilo_tmp_q  <= '0;
      cnt_q       <= '0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_whilo_q <= mem_whilo_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_valid_q <= mem_valid_d;
      hilo_tmp_q  <= hilo_tmp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_wd     = mem_wd_q;
  assign mem_wreg   = mem_wreg_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_whilo  = mem_whilo_q;
  assign mem_hi     = mem_hi_q;
  assign mem_lo     = mem_lo_q;
  assign mem_valid  = mem_valid_q;
  assign hilo_tmp_o = hilo_tmp_q;
  assign cnt_o      = cnt_q;

  stall_monotone_a: assert property (@(posedge clk) disable iff (rst)
    !(stall[MEM_IDX] && !stall[EX_IDX]));

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - table-driven bench for ex_mem_reg plus hand sequences for corner cases
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_tmp_i;
  logic [1:0]  cnt_i;
`ifdef EX_MEM_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_valid;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_tmp_i(hilo_tmp_i), .cnt_i(cnt_i),
`ifdef EX_MEM_FLUSH_EN
    .flush(flush),
`endif
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
    .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_valid;
    logic [63:0] e_tmp;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic [5:0] st,
                     input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                     input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                     input logic [63:0] tmp, input logic [1:0] cnt,
                     input logic [4:0] e_wd, input logic e_wreg, input logic [31:0] e_wdata,
                     input logic e_whilo, input logic [31:0] e_hi, input logic [31:0] e_lo,
                     input logic e_valid, input logic [63:0] e_tmp, input logic [1:0] e_cnt);
    vec_t v;
    v.name = name; v.rst = r; v.stall = st; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.whilo = whilo; v.hi = hi; v.lo = lo; v.tmp = tmp; v.cnt = cnt;
    v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_whilo = e_whilo;
    v.e_hi = e_hi; v.e_lo = e_lo; v.e_valid = e_valid; v.e_tmp = e_tmp; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata;
    ex_whilo = v.whilo; ex_hi = v.hi; ex_lo = v.lo; hilo_tmp_i = v.tmp; cnt_i = v.cnt;
  endtask

  task automatic check_all(input vec_t v);
    check({v.name, ".mem_wd"},     64'(mem_wd),     64'(v.e_wd));
    check({v.name, ".mem_wreg"},   64'(mem_wreg),   64'(v.e_wreg));
    check({v.name, ".mem_wdata"},  64'(mem_wdata),  64'(v.e_wdata));
    check({v.name, ".mem_whilo"},  64'(mem_whilo),  64'(v.e_whilo));
    check({v.name, ".mem_hi"},     64'(mem_hi),     64'(v.e_hi));
    check({v.name, ".mem_lo"},     64'(mem_lo),     64'(v.e_lo));
    check({v.name, ".mem_valid"},  64'(mem_valid),  64'(v.e_valid));
    check({v.name, ".hilo_tmp_o"}, hilo_tmp_o,      v.e_tmp);
    check({v.name, ".cnt_o"},      64'(cnt_o),      64'(v.e_cnt));
  endtask

  initial begin
    vec_t v;
    // name, rst, stall, wd, wreg, wdata, whilo, hi, lo, tmp, cnt | expected outputs
    add("rst0", 1, 6'b000000, 5'd7, 1, 32'hAAAA5555, 1, 32'h11111111, 32'h22222222, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0, 2'd0);
    add("rst1", 1, 6'b001111, 5'd7, 1, 32'hAAAA5555, 1, 32'h11111111, 32'h22222222, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0, 2'd0);
    add("adv", 0, 6'b000000, 5'd3, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 64'h55, 2'd2,
        5'd3, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("bub", 0, 6'b001111, 5'd9, 1, 32'h00001234, 1, 32'h5, 32'h6, 64'h0000_0001_FFFF_FFFE, 2'd1,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0000_0001_FFFF_FFFE, 2'd1);
    add("acc2", 0, 6'b000000, 5'd0, 0, 32'h0, 1, 32'hCAFE0001, 32'hBEEF0002, 64'h77, 2'd2,
        5'd0, 0, 32'h0, 1, 32'hCAFE0001, 32'hBEEF0002, 1, 64'h0, 2'd0);
    add("load", 0, 6'b000000, 5'd4, 1, 32'h12345678, 0, 32'h0, 32'h0, 64'h0, 2'd0,
        5'd4, 1, 32'h12345678, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("hold1", 0, 6'b011111, 5'd31, 0, 32'h00000001, 1, 32'h9, 32'h9, 64'h99, 2'd3,
        5'd4, 1, 32'h12345678, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("hold2", 0, 6'b011111, 5'd31, 0, 32'h00000002, 1, 32'h9, 32'h9, 64'h99, 2'd3,
        5'd4, 1, 32'h12345678, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("hold3", 0, 6'b111111, 5'd31, 0, 32'h00000003, 1, 32'h9, 32'h9, 64'h99, 2'd3,
        5'd4, 1, 32'h12345678, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("cnt3", 0, 6'b001111, 5'd2, 1, 32'h3, 0, 32'h0, 32'h0, 64'h8000_0000_0000_0001, 2'd3,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h8000_0000_0000_0001, 2'd3);
    add("nowreg", 0, 6'b000000, 5'd17, 0, 32'h0BADF00D, 0, 32'h0, 32'h0, 64'h0, 2'd0,
        5'd17, 0, 32'h0BADF00D, 0, 32'h0, 32'h0, 1, 64'h0, 2'd0);
    add("bub2", 0, 6'b001111, 5'd1, 1, 32'h1, 0, 32'h0, 32'h0, 64'h0000_ABCD_0000_1234, 2'd1,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0000_ABCD_0000_1234, 2'd1);
    add("holdb", 0, 6'b011111, 5'd1, 1, 32'h1, 1, 32'h3, 32'h3, 64'h1111, 2'd2,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0000_ABCD_0000_1234, 2'd1);
    add("rstmid", 1, 6'b001111, 5'd1, 1, 32'h1, 1, 32'h3, 32'h3, 64'h2222, 2'd2,
        5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 64'h0, 2'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      @(posedge clk);
      #1;
      check_all(v);
    end

    // Registered outputs must ignore input changes until the next edge.
    rst = 0; stall = 6'b000000; ex_wd = 5'd12; ex_wreg = 1; ex_wdata = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    check("nocomb.load", 64'(mem_wdata), 64'h0F0F0F0F);
    ex_wdata = 32'hF0F0F0F0;
    #3;
    check("nocomb.same", 64'(mem_wdata), 64'h0F0F0F0F);
    @(posedge clk);
    #1;
    check("nocomb.next", 64'(mem_wdata), 64'hF0F0F0F0);

`ifdef EX_MEM_FLUSH_EN
    // Flush wins over a full hold.
    flush = 1; stall = 6'b011111; ex_wdata = 32'h77777777;
    @(posedge clk);
    #1;
    flush = 0;
    check("flush.mem_valid", 64'(mem_valid), 64'h0);
    check("flush.mem_wdata", 64'(mem_wdata), 64'h0);
    check("flush.mem_wd",    64'(mem_wd),    64'h0);
    check("flush.mem_wreg",  64'(mem_wreg),  64'h0);
    // Flush also discards accumulate state held by a bubble.
    stall = 6'b001111; hilo_tmp_i = 64'h1234; cnt_i = 2'd1;
    @(posedge clk);
    #1;
    check("flushacc.pre", 64'(cnt_o), 64'h1);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    check("flushacc.cnt", 64'(cnt_o), 64'h0);
    check("flushacc.tmp", hilo_tmp_o, 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
